counter_seq: RTL and testbench

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_seq.sv | 65 ++++++
 tb/tb_counter_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq.sv
// Armed terminal counter: start_strb arms and clears, max+1 qualified enables yield one strb pulse.
// Optional busy output enabled by defining COUNTER_SEQ_BUSY_EN.
module counter_seq #(
    parameter int unsigned     dw  = 8,
    parameter logic [dw-1:0]   max = {dw{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          start_strb,
    output logic [dw-1:0] cntr,
    output logic          strb
`ifdef COUNTER_SEQ_BUSY_EN
    ,
    output logic          busy
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [dw-1:0] cntr_q, cntr_d;
    logic          strb_q, strb_d;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cntr_q  <= '0;
            strb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            strb_q  <= strb_d;
        end
    end

    // Next state: start_strb overrides any enable on the same edge
    always_comb begin
        state_d = state_q;
        cntr_d  = cntr_q;
        strb_d  = 1'b0;
        if (start_strb) begin
            state_d = RUN;
            cntr_d  = '0;
        end else if ((state_q == RUN) && enable) begin
            if (cntr_q == max) begin
                state_d = IDLE;
                cntr_d  = '0;
                strb_d  = 1'b1;
            end else begin
                cntr_d  = cntr_q + dw'(1);
            end
        end
    end

    assign cntr = cntr_q;
    assign strb = strb_q;

`ifdef COUNTER_SEQ_BUSY_EN
    assign busy = (state_q == RUN);
`endif

endmodule

// File: tb/tb_counter_seq.sv
// Directed self-checking bench for counter_seq: instances with max=7, max=5 and max=0 (dw=3).
module tb_counter_seq;

    logic       clk;
    logic       reset;
    logic       en_a, start_a, en_b, start_b;
    logic [2:0] cntr7, cntr5, cntr0;
    logic       strb7, strb5, strb0;
`ifdef COUNTER_SEQ_BUSY_EN
    logic       busy7, busy5, busy0;
`endif

    int total = 0;
    int bad   = 0;

    counter_seq #(.dw(3), .max(3'd7)) u7 (
        .clk(clk), .reset(reset), .enable(en_a), .start_strb(start_a),
        .cntr(cntr7), .strb(strb7)
`ifdef COUNTER_SEQ_BUSY_EN
        , .busy(busy7)
`endif
    );

    counter_seq #(.dw(3), .max(3'd5)) u5 (
        .clk(clk), .reset(reset), .enable(en_b), .start_strb(start_b),
        .cntr(cntr5), .strb(strb5)
`ifdef COUNTER_SEQ_BUSY_EN
        , .busy(busy5)
`endif
    );

    counter_seq #(.dw(3), .max(3'd0)) u0 (
        .clk(clk), .reset(reset), .enable(en_b), .start_strb(start_b),
        .cntr(cntr0), .strb(strb0)
`ifdef COUNTER_SEQ_BUSY_EN
        , .busy(busy0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp7(input string tag, input int c, input logic s, input logic b);
        chk({tag, "_cntr7"}, 32'(cntr7), 32'(c));
        chk({tag, "_strb7"}, 32'(strb7), 32'(s));
`ifdef COUNTER_SEQ_BUSY_EN
        chk({tag, "_busy7"}, 32'(busy7), 32'(b));
`else
        if (b === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic exp5(input string tag, input int c, input logic s, input logic b);
        chk({tag, "_cntr5"}, 32'(cntr5), 32'(c));
        chk({tag, "_strb5"}, 32'(strb5), 32'(s));
`ifdef COUNTER_SEQ_BUSY_EN
        chk({tag, "_busy5"}, 32'(busy5), 32'(b));
`else
        if (b === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic exp0(input string tag, input logic s);
        chk({tag, "_cntr0"}, 32'(cntr0), 32'd0);
        chk({tag, "_strb0"}, 32'(strb0), 32'(s));
`ifdef COUNTER_SEQ_BUSY_EN
        chk({tag, "_busy0"}, 32'(busy0), 32'd0);
`endif
    endtask

    task automatic arm_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        en_a    = 1'b0;
        start_a = 1'b0;
        en_b    = 1'b0;
        start_b = 1'b0;

        // Reset state
        #2;
        exp7("rst", 0, 1'b0, 1'b0);
        exp5("rst", 0, 1'b0, 1'b0);
        exp0("rst", 1'b0);
        #11 reset = 1'b1;

        // First edge after release is functional: arm, then spaced enables
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp7("arm", 0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            en_a = 1'b1;
            tick();
            en_a = 1'b0;
            exp7("spaced", i % 8, (i == 8), (i < 8));
            for (int g = 0; g < 4; g++) begin
                tick();
                exp7("gap", i % 8, 1'b0, (i < 8));
            end
        end

        // Enables ignored while idle
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp7("idle", 0, 1'b0, 1'b0);
        end
        en_a = 1'b0;

        // max=5 with enable held 10 cycles; max=0 strobes on the first enable
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        exp5("arm5", 0, 1'b0, 1'b1);
        en_b = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp5("held5", (k < 6) ? k : 0, (k == 6), (k < 6));
            exp0("held0", (k == 1));
        end
        en_b = 1'b0;
        exp7("quiet", 0, 1'b0, 1'b0);

        // Restart during run: 4 enables, re-arm with enable still high, 8 more
        arm_a();
        en_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp7("pre", k, 1'b0, 1'b1);
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp7("rearm", 0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp7("post", k % 8, (k == 8), (k < 8));
        end
        en_a = 1'b0;
        tick();
        exp7("post_end", 0, 1'b0, 1'b0);

        // start_strb coincident with the terminal enable wins
        arm_a();
        en_a = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp7("co_pre", k, 1'b0, 1'b1);
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp7("co_hit", 0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp7("co_post", k % 8, (k == 8), (k < 8));
        end
        en_a = 1'b0;

        // Asynchronous reset mid-count abandons the count
        arm_a();
        en_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp7("mid", k, 1'b0, 1'b1);
        end
        en_a = 1'b0;
        #3 reset = 1'b0;
        #1 exp7("async_rst", 0, 1'b0, 1'b0);
        tick();
        exp7("rst_held", 0, 1'b0, 1'b0);
        #4 reset = 1'b1;
        en_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp7("after_rst", 0, 1'b0, 1'b0);
        end
        en_a = 1'b0;

        // Asynchronous reset clears a pending strb immediately
        arm_a();
        en_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
        end
        en_a = 1'b0;
        exp7("strb_up", 0, 1'b1, 1'b0);
        #3 reset = 1'b0;
        #1 exp7("rst_strb", 0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        tick();
        exp7("final", 0, 1'b0, 1'b0);
        exp5("final", 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
